// File: rtl/tpu_mac.sv
// tpu_mac: systolic-array MAC processing element (define TPUMAC_SAT_EN for saturating accumulation)
module tpu_mac #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                WrEn,
  input  logic [BITS_AB-1:0]  Ain,
  input  logic [BITS_AB-1:0]  Bin,
  input  logic [BITS_C-1:0]   Cin,
  output logic [BITS_AB-1:0]  Aout,
  output logic [BITS_AB-1:0]  Bout,
  output logic [BITS_C-1:0]   Cout
);
  localparam int P = 2 * BITS_AB;
  logic signed [P-1:0]      prod;
  logic signed [BITS_C-1:0] prod_ext;
  logic signed [BITS_C-1:0] acc;
  assign prod     = P'($signed(Ain)) * P'($signed(Bin));
  assign prod_ext = BITS_C'(prod);
`ifdef TPUMAC_SAT_EN
  logic signed [BITS_C:0] sum;
  assign sum = (BITS_C+1)'($signed(Cout)) + (BITS_C+1)'(prod_ext);
  // clamp when the guard bit disagrees with the sign bit of the sum
  always_comb
    acc = (sum[BITS_C] != sum[BITS_C-1]) ?
          (sum[BITS_C] ? {1'b1, {(BITS_C-1){1'b0}}} : {1'b0, {(BITS_C-1){1'b1}}}) :
          sum[BITS_C-1:0];
`else
  assign acc = $signed(Cout) + prod_ext;
`endif
  // forward operands and load or accumulate C on every enabled edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      Aout <= '0;
      Bout <= '0;
      Cout <= '0;
    end else if (en) begin
      Aout <= Ain;
      Bout <= Bin;
      Cout <= WrEn ? Cin : acc;
    end
endmodule

// File: tb/tb_tpu_mac.sv
// tb_tpu_mac: scoreboard bench for tpu_mac with directed and random vectors
module tb_tpu_mac;
  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] c;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 1;
  logic        en = 0;
  logic        WrEn = 0;
  logic [7:0]  Ain = 0;
  logic [7:0]  Bin = 0;
  logic [15:0] Cin = 0;
  logic [7:0]  Aout;
  logic [7:0]  Bout;
  logic [15:0] Cout;
  logic [7:0]  ma = 0;
  logic [7:0]  mb = 0;
  logic [15:0] mc = 0;
  exp_t        q[$];
  int          n_vec = 0;
  int          n_err = 0;
  tpu_mac #(.BITS_AB(8), .BITS_C(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .WrEn(WrEn),
    .Ain(Ain), .Bin(Bin), .Cin(Cin),
    .Aout(Aout), .Bout(Bout), .Cout(Cout)
  );
  always #5 clk = ~clk;
  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [15:0] acc_model(logic [15:0] c, logic [7:0] a, logic [7:0] b);
    int s;
    s = int'($signed(c)) + int'($signed(a)) * int'($signed(b));
`ifdef TPUMAC_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction
  task automatic step(logic e, logic w, logic [7:0] a, logic [7:0] b, logic [15:0] c,
                      bit use_hand = 0, logic [15:0] hand = 0);
    en = e; WrEn = w; Ain = a; Bin = b; Cin = c;
    if (e) begin
      ma = a;
      mb = b;
      mc = w ? c : acc_model(mc, a, b);
    end
    if (use_hand) mc = hand;
    @(posedge clk);
    q.push_back('{a: ma, b: mb, c: mc});
    #1;
  endtask
  // monitor: compare the oldest expectation against the registered outputs
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("aout", 16'(Aout), 16'(e.a));
      check("bout", 16'(Bout), 16'(e.b));
      check("cout", Cout, e.c);
    end
  end
  initial begin
    en = 1; WrEn = 0; Ain = 8'($urandom); Bin = 8'($urandom); Cin = 16'($urandom);
    #2 rst_n = 0;
    #1;
    check("rst_a", 16'(Aout), 16'h0);
    check("rst_b", 16'(Bout), 16'h0);
    check("rst_c", Cout, 16'h0);
    repeat (3) begin
      @(posedge clk);
      #1;
      Ain = 8'($urandom); Bin = 8'($urandom); Cin = 16'($urandom); WrEn = 1'($urandom);
      check("rst_hold_c", Cout, 16'h0);
      check("rst_hold_a", 16'(Aout), 16'h0);
    end
    rst_n = 1;
    step(1, 1, 8'd5, 8'd7, 16'h1234, 1, 16'h1234);
    step(1, 1, 8'd1, 8'd2, 16'd10, 1, 16'd10);
    step(1, 0, 8'd3, 8'd4, 16'h9999, 1, 16'd22);
    step(1, 0, -8'sd2, 8'd5, 16'h9999, 1, 16'd12);
    step(1, 0, 8'h80, 8'h80, 16'h0, 1, 16'd16396);
    step(0, 1, 8'h11, 8'h22, 16'hAAAA, 1, 16'd16396);
    step(0, 0, 8'h7F, 8'h7F, 16'h5555, 1, 16'd16396);
    @(negedge clk);
    #1 rst_n = 0;
    #1;
    check("midrst_a", 16'(Aout), 16'h0);
    check("midrst_c", Cout, 16'h0);
    en = 1; WrEn = 0; Ain = 8'd9; Bin = 8'd9;
    @(posedge clk);
    #1;
    check("midrst_hold_c", Cout, 16'h0);
    rst_n = 1;
    ma = 0; mb = 0; mc = 0;
    step(1, 1, 8'd0, 8'd0, 16'd32767, 1, 16'd32767);
`ifdef TPUMAC_SAT_EN
    step(1, 0, 8'd1, 8'd1, 16'h0, 1, 16'h7FFF);
    step(1, 1, 8'd0, 8'd0, 16'h8000, 1, 16'h8000);
    step(1, 0, 8'hFF, 8'd1, 16'h0, 1, 16'h8000);
`else
    step(1, 0, 8'd1, 8'd1, 16'h0, 1, 16'h8000);
    step(1, 1, 8'd0, 8'd0, 16'h8000, 1, 16'h8000);
    step(1, 0, 8'hFF, 8'd1, 16'h0, 1, 16'h7FFF);
`endif
    for (int r = 0; r < 100; r++) begin
      step(1, 1, 8'($urandom), 8'($urandom), 16'($urandom));
      for (int i = 0; i < 100; i++)
        step(1, 0, 8'($urandom), 8'($urandom), 16'($urandom));
    end
    repeat (2) @(negedge clk);
    #1;
    if (q.size() != 0) check("drain", 16'(q.size()), 16'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
